// File: rtl/ddr3_read_sequencer.sv
// Issues a credit-throttled block of MIG reads and forwards returned beats to the USB/DAC FIFO.
// Data path latency 1 cycle; app_en/app_addr hold until app_rdy, and issue stalls when FIFO credits run out.
module ddr3_read_sequencer #(
  parameter int ADDR_W     = 29,
  parameter int DATA_W     = 256,
  parameter int CNT_W      = 6,
  parameter int ADDR_STEP  = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int FIFO_SLACK = 4,
  parameter int MAX_OUT    = 16
) (
  input  logic                          clk,
  input  logic                          sys_rst,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             rd_base_addr,
  input  logic [CNT_W-1:0]              rd_cnt,
  input  logic                          init_calib_complete,
  output logic [ADDR_W-1:0]             app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  input  logic [DATA_W-1:0]             app_rd_data,
  input  logic                          app_rd_data_valid,
  output logic [DATA_W-1:0]             fifo_din,
  output logic                          fifo_wr_en,
  input  logic [$clog2(FIFO_DEPTH):0]   fifo_wr_data_count,
  output logic                          busy,
  output logic                          done,
  output logic                          err_unexpected
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int SUM_W = OUT_W + $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [2:0] {IDLE, WAIT_CAL, ISSUE, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] out_next;
  logic [SUM_W-1:0] credit_sum;
  logic             accept;
  logic             ret;
  logic             stray;
  logic             credit_ok;

  assign app_cmd = 3'b001;
  assign accept  = app_en & app_rdy;
  assign ret     = app_rd_data_valid & (outstanding != '0);
  assign stray   = app_rd_data_valid & (outstanding == '0);

  always_comb begin
    out_next = outstanding;
    if (accept && !ret)
      out_next = outstanding + 1'b1;
    else if (!accept && ret)
      out_next = outstanding - 1'b1;
  end

  // Credits are judged on the count as it will stand after this edge, so a
  // command can follow an accept in the very next cycle without over-issuing.
  assign credit_sum = SUM_W'(out_next) + SUM_W'(fifo_wr_data_count) + SUM_W'(FIFO_SLACK);
  assign credit_ok  = (out_next < OUT_W'(MAX_OUT)) && (credit_sum < SUM_W'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state          <= IDLE;
      app_addr       <= '0;
      app_en         <= 1'b0;
      fifo_din       <= '0;
      fifo_wr_en     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err_unexpected <= 1'b0;
      remaining      <= '0;
      outstanding    <= '0;
    end else begin
      fifo_wr_en  <= ret;
      fifo_din    <= app_rd_data;
      outstanding <= out_next;
      done        <= 1'b0;
      if (stray)
        err_unexpected <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            app_addr       <= rd_base_addr;
            remaining      <= rd_cnt;
            busy           <= 1'b1;
            err_unexpected <= stray;
            if (rd_cnt == '0)
              state <= DONE;
            else if (!init_calib_complete)
              state <= WAIT_CAL;
            else
              state <= ISSUE;
          end
        end
        WAIT_CAL: begin
          if (init_calib_complete)
            state <= ISSUE;
        end
        ISSUE: begin
          if (accept) begin
            app_addr  <= app_addr + ADDR_W'(ADDR_STEP);
            remaining <= remaining - 1'b1;
            if (remaining == CNT_W'(1)) begin
              app_en <= 1'b0;
              state  <= DRAIN;
            end else begin
              app_en <= credit_ok;
            end
          end else if (!app_en) begin
            app_en <= credit_ok;
          end
        end
        DRAIN: begin
          if (outstanding == '0)
            state <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_read_sequencer.sv
// Bench for ddr3_read_sequencer: vector table for the basic burst, directed corner
// sequences, then randomized transfers against a transaction-level MIG/FIFO model.
module tb_ddr3_read_sequencer;

  localparam int MAX_OUT = 16;
  localparam int DEPTH   = 64;
  localparam int SLACK   = 4;
  localparam int STEP    = 8;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic          start;
  logic [28:0]   rd_base_addr;
  logic [5:0]    rd_cnt;
  logic          init_calib_complete;
  logic [28:0]   app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [255:0]  app_rd_data;
  logic          app_rd_data_valid;
  logic [255:0]  fifo_din;
  logic          fifo_wr_en;
  logic [6:0]    fifo_wr_data_count;
  logic          busy;
  logic          done;
  logic          err_unexpected;

  ddr3_read_sequencer dut (
    .clk                 (clk),
    .sys_rst             (sys_rst),
    .start               (start),
    .rd_base_addr        (rd_base_addr),
    .rd_cnt              (rd_cnt),
    .init_calib_complete (init_calib_complete),
    .app_addr            (app_addr),
    .app_cmd             (app_cmd),
    .app_en              (app_en),
    .app_rdy             (app_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .fifo_din            (fifo_din),
    .fifo_wr_en          (fifo_wr_en),
    .fifo_wr_data_count  (fifo_wr_data_count),
    .busy                (busy),
    .done                (done),
    .err_unexpected      (err_unexpected)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int           cyc = 0;
  int           mod_out = 0;
  int           fifo_occ = 0;
  int           cnt_drv = 0;
  int           last_due = 0;
  int           n_acc, n_wr, n_done;
  int           due_q[$];
  logic [255:0] data_q[$];
  logic [28:0]  acc_q[$];
  logic [28:0]  exp_addr;
  logic         exp_wr = 1'b0;
  logic [255:0] exp_din;
  logic         prev_en = 1'b0;
  logic         prev_hold = 1'b0;
  logic [28:0]  prev_addr;
  bit           rand_rdy = 1'b0;
  bit           rdy_val = 1'b1;
  bit           fifo_model = 1'b0;
  bit           stray_req = 1'b0;
  int           cnt_val = 0;
  int           lat_lo = 3;
  int           lat_hi = 3;

  typedef struct packed {
    logic        start;
    logic        vld;
    logic [7:0]  tag;
    logic        en;
    logic [28:0] addr;
    logic        wr;
    logic [7:0]  wtag;
    logic        busy;
    logic        done;
  } vec_t;
  vec_t tbl [13];

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_d(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock of the MIG + FIFO model: check what the last edge produced, then drive the next edge.
  task automatic tick();
    int due;
    @(negedge clk);
    cyc++;
    chk_i("fifo_wr_en", int'(fifo_wr_en), int'(exp_wr));
    if (exp_wr) chk_d("fifo_din", fifo_din, exp_din);
    if (prev_hold) begin
      chk_i("hold_en", int'(app_en), 1);
      chk_i("hold_addr", int'(app_addr), int'(prev_addr));
    end
    if (app_en && !prev_en)
      chk_i("credit", int'((mod_out < MAX_OUT) && (mod_out + cnt_drv + SLACK < DEPTH)), 1);
    if (app_en) chk_i("app_cmd", int'(app_cmd), 1);
    if (fifo_wr_en) begin
      n_wr++;
      if (fifo_model) fifo_occ++;
    end
    if (done) n_done++;
    if (fifo_model) chk_i("fifo_overflow", int'(fifo_occ <= DEPTH), 1);

    start   = 1'b0;
    app_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_val;
    app_rd_data_valid = 1'b0;
    app_rd_data = rnd256();
    exp_wr = 1'b0;
    if (stray_req) begin
      stray_req = 1'b0;
      app_rd_data_valid = 1'b1;
      exp_wr = (mod_out > 0);
      exp_din = app_rd_data;
      if (mod_out > 0) mod_out--;
    end else if (due_q.size() != 0 && due_q[0] <= cyc) begin
      app_rd_data_valid = 1'b1;
      app_rd_data = data_q.pop_front();
      void'(due_q.pop_front());
      exp_wr = 1'b1;
      exp_din = app_rd_data;
      mod_out--;
    end
    if (fifo_model) begin
      if (fifo_occ > 0 && $urandom_range(0, 2) == 0) fifo_occ--;
      cnt_drv = fifo_occ;
    end else begin
      cnt_drv = cnt_val;
    end
    fifo_wr_data_count = 7'(cnt_drv);

    prev_en   = app_en;
    prev_addr = app_addr;
    prev_hold = app_en && !app_rdy && sys_rst;
    if (app_en && app_rdy) begin
      chk_i("acc_addr", int'(app_addr), int'(exp_addr));
      acc_q.push_back(app_addr);
      exp_addr = exp_addr + 29'(STEP);
      n_acc++;
      mod_out++;
      chk_i("max_out", int'(mod_out <= MAX_OUT), 1);
      due = cyc + $urandom_range(lat_lo, lat_hi);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      data_q.push_back(rnd256());
      due_q.push_back(due);
    end
  endtask

  task automatic do_start(input logic [28:0] base, input int cnt);
    rd_base_addr = base;
    rd_cnt = 6'(cnt);
    start = 1'b1;
    exp_addr = base;
    n_acc = 0;
    n_wr = 0;
    n_done = 0;
    acc_q.delete();
  endtask

  task automatic wait_done(input int cnt, input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      tick();
      n++;
    end
    chk_i("done_seen", n_done, 1);
    chk_i("busy_at_done", int'(busy), 0);
    chk_i("accepts", n_acc, cnt);
    chk_i("writes", n_wr, cnt);
    tick();
    chk_i("done_one_pulse", int'(done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sys_rst = 1'b0;
    start = 1'b0;
    rd_base_addr = '0;
    rd_cnt = '0;
    init_calib_complete = 1'b1;
    app_rdy = 1'b1;
    app_rd_data = '0;
    app_rd_data_valid = 1'b0;
    fifo_wr_data_count = '0;
    repeat (3) @(negedge clk);
    chk_i("rst_app_en", int'(app_en), 0);
    chk_i("rst_app_addr", int'(app_addr), 0);
    chk_i("rst_app_cmd", int'(app_cmd), 1);
    chk_i("rst_fifo_wr_en", int'(fifo_wr_en), 0);
    chk_d("rst_fifo_din", fifo_din, 256'h0);
    chk_i("rst_busy", int'(busy), 0);
    chk_i("rst_done", int'(done), 0);
    chk_i("rst_err", int'(err_unexpected), 0);
    sys_rst = 1'b1;

    // Basic burst: base 0x100, 4 beats, app_rdy high, read latency 3
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 29'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 29'h000, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 29'h100, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 29'h108, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 29'h110, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hA1, 1'b1, 29'h118, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 29'h000, 1'b1, 8'hA1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 29'h000, 1'b1, 8'hA2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'hA4, 1'b0, 29'h000, 1'b1, 8'hA3, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 29'h000, 1'b1, 8'hA4, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 29'h000, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 29'h000, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 29'h000, 1'b0, 8'h00, 1'b0, 1'b0};
    rd_base_addr = 29'h100;
    rd_cnt = 6'd4;
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      cyc++;
      chk_i($sformatf("tbl%0d_en", k), int'(app_en), int'(tbl[k].en));
      if (tbl[k].en) chk_i($sformatf("tbl%0d_addr", k), int'(app_addr), int'(tbl[k].addr));
      chk_i($sformatf("tbl%0d_wr", k), int'(fifo_wr_en), int'(tbl[k].wr));
      if (tbl[k].wr) chk_d($sformatf("tbl%0d_din", k), fifo_din, {32{tbl[k].wtag}});
      chk_i($sformatf("tbl%0d_busy", k), int'(busy), int'(tbl[k].busy));
      chk_i($sformatf("tbl%0d_done", k), int'(done), int'(tbl[k].done));
      start = tbl[k].start;
      app_rd_data_valid = tbl[k].vld;
      app_rd_data = {32{tbl[k].tag}};
    end
    last_due = cyc;

    // app_rdy low for 5 cycles at the 2nd command; a start while busy must be ignored
    rdy_val = 1'b1;
    do_start(29'h100, 4);
    for (int n = 0; n < 20 && n_acc < 1; n++) tick();
    rdy_val = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_i("stall_en", int'(app_en), 1);
      chk_i("stall_addr", int'(app_addr), 'h108);
      if (i == 2) begin
        start = 1'b1;
        rd_base_addr = 29'h5000;
        rd_cnt = 6'd9;
      end
    end
    rdy_val = 1'b1;
    wait_done(4, 200);

    // FIFO credit throttling: count 60 blocks issue, 59 lets it through
    cnt_val = 60;
    lat_lo = 2;
    lat_hi = 4;
    do_start(29'h2000, 2);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_i("credit_block_en", int'(app_en), 0);
    end
    cnt_val = 59;
    wait_done(2, 200);
    cnt_val = 0;

    // Zero-length request
    do_start(29'h40, 0);
    tick();
    chk_i("cnt0_busy", int'(busy), 1);
    chk_i("cnt0_done_early", int'(done), 0);
    chk_i("cnt0_en1", int'(app_en), 0);
    tick();
    chk_i("cnt0_done", int'(done), 1);
    chk_i("cnt0_busy_low", int'(busy), 0);
    chk_i("cnt0_en2", int'(app_en), 0);
    tick();
    chk_i("cnt0_done_pulse", int'(done), 0);
    chk_i("cnt0_accepts", n_acc, 0);

    // Waiting for calibration
    init_calib_complete = 1'b0;
    do_start(29'h300, 3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_i("cal_wait_en", int'(app_en), 0);
      chk_i("cal_wait_busy", int'(busy), 1);
    end
    init_calib_complete = 1'b1;
    tick();
    chk_i("cal_issue_state_en", int'(app_en), 0);
    tick();
    chk_i("cal_first_en", int'(app_en), 1);
    chk_i("cal_first_addr", int'(app_addr), 'h300);
    wait_done(3, 200);

    // Address wrap at the top of the 29-bit space
    do_start(29'h1FFFFFF8, 2);
    wait_done(2, 100);
    chk_i("wrap_n", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk_i("wrap_a0", int'(acc_q[0]), 'h1FFFFFF8);
      chk_i("wrap_a1", int'(acc_q[1]), 0);
    end

    // Reset mid-issue, then a stray beat from the abandoned transfer
    do_start(29'h800, 8);
    for (int n = 0; n < 30 && n_acc < 2; n++) tick();
    sys_rst = 1'b0;
    #1;
    chk_i("mid_rst_en", int'(app_en), 0);
    chk_i("mid_rst_addr", int'(app_addr), 0);
    chk_i("mid_rst_busy", int'(busy), 0);
    chk_i("mid_rst_wr", int'(fifo_wr_en), 0);
    data_q.delete();
    due_q.delete();
    mod_out = 0;
    exp_wr = 1'b0;
    prev_hold = 1'b0;
    prev_en = 1'b0;
    last_due = cyc;
    tick();
    tick();
    sys_rst = 1'b1;
    tick();
    stray_req = 1'b1;
    tick();
    tick();
    chk_i("stray_err", int'(err_unexpected), 1);
    do_start(29'h900, 1);
    tick();
    chk_i("err_cleared_on_start", int'(err_unexpected), 0);
    wait_done(1, 100);

    // Randomized transfers against the MIG/FIFO model
    fifo_occ = 0;
    fifo_model = 1'b1;
    rand_rdy = 1'b1;
    lat_lo = 2;
    lat_hi = 12;
    for (int t = 0; t < 25; t++) begin
      logic [28:0] base;
      int cnt;
      cnt = $urandom_range(1, 40);
      base = 29'($urandom);
      if ($urandom_range(0, 4) == 0) base = 29'h1FFFFF00 | 29'($urandom_range(0, 255));
      init_calib_complete = ($urandom_range(0, 3) != 0);
      do_start(base, cnt);
      if (!init_calib_complete) begin
        repeat ($urandom_range(1, 4)) tick();
        init_calib_complete = 1'b1;
      end
      wait_done(cnt, 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_read_sequencer.md
Name: ddr3_read_sequencer

Overview:
Read-side counterpart of the USB-to-DDR3 write path. On a start pulse it issues a block of read commands to the DDR3 MIG user interface, from a base address for a given beat count. It forwards the returned 256-bit beats into the DDR3-to-USB/DAC FIFO. Command issue is throttled by credits so the downstream FIFO can never overflow.

Parameters:
ADDR_W, 29, MIG app_addr width
DATA_W, 256, app_rd_data / FIFO din width
CNT_W, 6, beat-count width
ADDR_STEP, 8, app_addr increment per 256-bit beat (32-bit DDR3, BL8)
FIFO_DEPTH, 64, downstream FIFO depth in DATA_W words
FIFO_SLACK, 4, credit margin covering FIFO count latency
MAX_OUT, 16, maximum reads in flight

Ports:
clk  in  1  single clock (MIG ui_clk domain)
sys_rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; ignored while busy
rd_base_addr  in  ADDR_W  first beat address, sampled on accepted start
rd_cnt  in  CNT_W  beats to read, sampled on accepted start
init_calib_complete  in  1  MIG calibration done
app_addr  out  ADDR_W  MIG command address
app_cmd  out  3  MIG command; 3'b001 (read) whenever app_en=1
app_en  out  1  MIG command valid
app_rdy  in  1  MIG command accept
app_rd_data  in  DATA_W  MIG read data
app_rd_data_valid  in  1  MIG read data valid
fifo_din  out  DATA_W  data to downstream FIFO
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data_count  in  $clog2(FIFO_DEPTH)+1  FIFO occupancy
busy  out  1  high from accepted start until done
done  out  1  one-cycle completion pulse
err_unexpected  out  1  sticky: read data returned with nothing outstanding

Behaviour:
- Reset (async assert, sync release): state IDLE; app_addr=0, app_cmd=3'b001, app_en=0, fifo_din=0, fifo_wr_en=0, busy=0, done=0, err_unexpected=0; internal counters zeroed. Reset mid-operation abandons the transfer immediately.
- States: IDLE, WAIT_CAL, ISSUE, DRAIN, DONE.
- IDLE: start=1 latches rd_base_addr and rd_cnt, clears err_unexpected, sets busy next cycle.
  - rd_cnt=0 -> DONE
  - else init_calib_complete=0 -> WAIT_CAL
  - else -> ISSUE
- WAIT_CAL: -> ISSUE the cycle after init_calib_complete is seen high.
- ISSUE: app_en rises only when outstanding < MAX_OUT and outstanding + fifo_wr_data_count + FIFO_SLACK < FIFO_DEPTH.
  - Once asserted, app_en and app_addr hold stable until app_en&app_rdy, regardless of credit changes.
  - On accept: app_addr += ADDR_STEP, modulo 2^ADDR_W (wraps); remaining -= 1; outstanding += 1.
  - app_en deasserts in the cycle after the final accept; state -> DRAIN.
  - Back-to-back accepts (one per cycle) are required when app_rdy and credits allow.
- DRAIN: -> DONE when outstanding=0.
- DONE: done=1 for exactly one cycle, busy=0 from the next cycle, -> IDLE.
- Outstanding counter: accept and valid in the same cycle leave it unchanged.
- Data path, 1-cycle latency, order preserved: fifo_wr_en(t+1)=app_rd_data_valid(t); fifo_din(t+1)=app_rd_data(t).
- app_rd_data_valid with outstanding=0 (any state): beat dropped (no fifo_wr_en), err_unexpected set, counter stays 0.
- start while busy: ignored, no effect on latched values.

Test Plan:
- base=0x100, cnt=4, app_rdy=1, read latency 3 -> app_addr 0x100,0x108,0x110,0x118 on 4 consecutive cycles; 4 fifo_wr_en in order with matching data; done one pulse; busy low after.
- cnt=4, app_rdy low 5 cycles at 2nd command -> app_en held, app_addr=0x108 stable throughout; exactly 4 accepts; no duplicate or skipped address.
- FIFO_DEPTH=64, SLACK=4, fifo_wr_data_count=60, cnt=2 -> no app_en; drop count to 59 -> issue resumes; both beats written.
- cnt=0 -> done pulse 2 cycles after start; app_en never asserted.
- start with init_calib_complete=0 -> stays WAIT_CAL, app_en=0; raise calib -> issue begins next cycle.
- base=0x1FFFFFF8, cnt=2 -> addresses 0x1FFFFFF8 then 0x00000000.
- sys_rst low during ISSUE -> outputs reset immediately; a later stray app_rd_data_valid -> err_unexpected=1, no fifo_wr_en.
